mem_stage_lsu: RTL and testbench

Parametrised memory-stage load/store unit for the in-order pipeline: accepts one ALU-resolved operation per handshake, issues at most one data-memory request, waits a variable number of cycles for the response, then delivers an aligned, sign/zero-extended writeback value. Replaces the combinational single-cycle memory stage:
- Adds a request/response memory handshake, back-pressure on both sides, flush and 64-bit support.
- Sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_lsu_if.sv | 59 +++++
 rtl/mem_stage_lsu.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Handshake and data-memory bus bundle for mem_stage_lsu.
// master = pipeline/memory side, slave = the LSU itself.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NB = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic              in_re;
  logic              in_we;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [4:0]        in_rd;

  logic              dmem_req;
  logic [ADDR_W-1:0] dmem_addr;
  logic [NB-1:0]     dmem_rmask;
  logic [NB-1:0]     dmem_wmask;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_resp;
  logic [DATA_W-1:0] dmem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;

  modport master (
    output in_valid, in_re, in_we,
    output in_funct3, in_addr,
    output in_wdata, in_rd,
    input  in_ready,
    input  dmem_req, dmem_addr,
    input  dmem_rmask, dmem_wmask,
    input  dmem_wdata,
    output dmem_resp, dmem_rdata,
    input  out_valid, out_rd,
    input  out_data, out_misalign,
    output out_ready
  );

  modport slave (
    input  in_valid, in_re, in_we,
    input  in_funct3, in_addr,
    input  in_wdata, in_rd,
    output in_ready,
    output dmem_req, dmem_addr,
    output dmem_rmask, dmem_wmask,
    output dmem_wdata,
    input  dmem_resp, dmem_rdata,
    output out_valid, out_rd,
    output out_data, out_misalign,
    input  out_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding request, sized/extended loads.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  mem_stage_lsu_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     rmask_q, rmask_d;
  logic [NB-1:0]     wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [OW-1:0]     off_q, off_d;
  logic [1:0]        szl_q, szl_d;
  logic              uns_q, uns_d;
  logic              st_q, st_d;
  logic [4:0]        rd_q, rd_d;
  logic              kill_q, kill_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [4:0]        ord_q, ord_d;
  logic              omis_q, omis_d;

  logic              acc;
  logic              mem_op;
  logic [2:0]        f3;
  logic [1:0]        szl;
  logic [3:0]        sz_bytes;
  logic [OW-1:0]     size_m1;
  logic [OW-1:0]     off_raw;
  logic [OW-1:0]     off;
  logic [8:0]        lane_ones;
  logic [NB-1:0]     bmask;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] dmask;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ld;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mis;
`endif

  assign f3     = bus.in_funct3;
  assign mem_op = bus.in_re | bus.in_we;

  assign bus.in_ready = (state_q == S_IDLE)
                      && (!ov_q || bus.out_ready)
                      && !flush;
  assign acc = bus.in_valid && bus.in_ready;

  // log2 of access size; d only exists on the 64-bit build
  always_comb begin
    szl = 2'd0;
    unique case (1'b1)
      f3[1:0] == 2'd1: szl = 2'd1;
      f3[1:0] == 2'd2: szl = 2'd2;
      (f3[1:0] == 2'd3) && !f3[2]
        && (DATA_W == 64): szl = 2'd3;
      default: szl = 2'd0;
    endcase
  end

  assign sz_bytes = 4'd1 << szl;
  assign size_m1  = OW'(sz_bytes - 4'd1);
  assign off_raw  = bus.in_addr[OW-1:0];
  assign off      = off_raw & ~size_m1;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis      = (off_raw & size_m1) != '0;
`endif

  assign lane_ones = (9'd1 << sz_bytes) - 9'd1;
  assign bmask     = NB'(lane_ones);
  assign mask      = bmask << off;

  always_comb begin
    dmask = '0;
    for (int i = 0; i < NB; i++) begin
      dmask[8*i +: 8] = {8{bmask[i]}};
    end
  end

  assign wd = (bus.in_wdata & dmask) << {off, 3'b000};

  assign sh = bus.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld = '0;
    unique case (1'b1)
      szl_q == 2'd1: begin
        if (uns_q) ld = DATA_W'(sh[15:0]);
        else       ld = DATA_W'($signed(sh[15:0]));
      end
      szl_q == 2'd2: begin
        if (uns_q) ld = DATA_W'(sh[31:0]);
        else       ld = DATA_W'($signed(sh[31:0]));
      end
      szl_q == 2'd3: ld = sh;
      default: begin
        if (uns_q) ld = DATA_W'(sh[7:0]);
        else       ld = DATA_W'($signed(sh[7:0]));
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    szl_d   = szl_q;
    uns_d   = uns_q;
    st_d    = st_q;
    rd_d    = rd_q;
    kill_d  = kill_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ord_d   = ord_q;
    omis_d  = omis_q;

    if (ov_q && bus.out_ready) ov_d = 1'b0;

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (acc) begin
          if (!mem_op) begin
            ov_d   = 1'b1;
            od_d   = DATA_W'(bus.in_addr);
            ord_d  = bus.in_rd;
            omis_d = 1'b0;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (mis) begin
            ov_d   = 1'b1;
            od_d   = '0;
            ord_d  = bus.in_rd;
            omis_d = 1'b1;
          end
`endif
          else begin
            state_d = S_REQ;
            addr_d  = {bus.in_addr[ADDR_W-1:OW],
                       {OW{1'b0}}};
            rmask_d = bus.in_we ? '0 : mask;
            wmask_d = bus.in_we ? mask : '0;
            wdata_d = bus.in_we ? wd : '0;
            off_d   = off;
            szl_d   = szl;
            uns_d   = f3[2];
            st_d    = bus.in_we;
            rd_d    = bus.in_rd;
            kill_d  = 1'b0;
          end
        end
      end
      state_q == S_REQ: begin
        state_d = S_WAIT;
        if (flush) kill_d = 1'b1;
      end
      state_q == S_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (bus.dmem_resp) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
          // a same-cycle flush discards the response too
          if (!kill_q && !flush) begin
            ov_d   = 1'b1;
            od_d   = st_q ? '0 : ld;
            ord_d  = rd_q;
            omis_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) ov_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      szl_q   <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      rd_q    <= '0;
      kill_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ord_q   <= '0;
      omis_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      szl_q   <= szl_d;
      uns_q   <= uns_d;
      st_q    <= st_d;
      rd_q    <= rd_d;
      kill_q  <= kill_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ord_q   <= ord_d;
      omis_q  <= omis_d;
    end
  end

  assign bus.dmem_req     = (state_q == S_REQ);
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_rmask   = rmask_q;
  assign bus.dmem_wmask   = wmask_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.out_rd       = ord_q;
  assign bus.out_misalign = omis_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: 32-bit and 64-bit instances side by side.
// sel picks which instance the shared stimulus drives and observes.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic sel = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_re = 1'b0;
  logic        in_we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        resp = 1'b0;
  logic [63:0] rdata = '0;
  logic        out_ready = 1'b1;

  int ntot = 0;
  int nbad = 0;
  int nreq = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
  mem_stage_lsu_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32)
  );
  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64)
  );

  assign if32.in_valid   = in_valid & ~sel;
  assign if32.in_re      = in_re;
  assign if32.in_we      = in_we;
  assign if32.in_funct3  = f3;
  assign if32.in_addr    = in_addr;
  assign if32.in_wdata   = in_wdata[31:0];
  assign if32.in_rd      = in_rd;
  assign if32.dmem_resp  = resp & ~sel;
  assign if32.dmem_rdata = rdata[31:0];
  assign if32.out_ready  = out_ready;

  assign if64.in_valid   = in_valid & sel;
  assign if64.in_re      = in_re;
  assign if64.in_we      = in_we;
  assign if64.in_funct3  = f3;
  assign if64.in_addr    = in_addr;
  assign if64.in_wdata   = in_wdata;
  assign if64.in_rd      = in_rd;
  assign if64.dmem_resp  = resp & sel;
  assign if64.dmem_rdata = rdata;
  assign if64.out_ready  = out_ready;

  logic        m_ready, m_req, m_ov, m_mis;
  logic [31:0] m_addr;
  logic [7:0]  m_rm, m_wm;
  logic [63:0] m_wd, m_od;
  logic [4:0]  m_rd;

  assign m_ready = sel ? if64.in_ready : if32.in_ready;
  assign m_req   = sel ? if64.dmem_req : if32.dmem_req;
  assign m_addr  = sel ? if64.dmem_addr : if32.dmem_addr;
  assign m_rm    = sel ? if64.dmem_rmask : {4'b0, if32.dmem_rmask};
  assign m_wm    = sel ? if64.dmem_wmask : {4'b0, if32.dmem_wmask};
  assign m_wd    = sel ? if64.dmem_wdata : {32'b0, if32.dmem_wdata};
  assign m_ov    = sel ? if64.out_valid : if32.out_valid;
  assign m_od    = sel ? if64.out_data : {32'b0, if32.out_data};
  assign m_rd    = sel ? if64.out_rd : if32.out_rd;
  assign m_mis   = sel ? if64.out_misalign : if32.out_misalign;

  always @(posedge clk) if (m_req) nreq <= nreq + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ntot++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // drive one op, return at the negedge after the accepting edge
  task automatic issue(input bit re, input bit we,
                       input logic [2:0] fn,
                       input logic [31:0] a,
                       input logic [63:0] wd,
                       input logic [4:0] rd,
                       input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_re = re; in_we = we; f3 = fn;
    in_addr = a; in_wdata = wd; in_rd = rd;
    #1 check({tag, ".rdy"}, 64'(m_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_re = 1'b0; in_we = 1'b0;
  endtask

  task automatic mem_op(input bit re, input bit we,
                        input logic [2:0] fn,
                        input logic [31:0] a,
                        input logic [63:0] wd,
                        input logic [63:0] rdat,
                        input int dly,
                        input logic [31:0] e_addr,
                        input logic [7:0] e_rm,
                        input logic [7:0] e_wm,
                        input logic [63:0] e_wd,
                        input logic [63:0] e_out,
                        input string tag);
    int n0;
    issue(re, we, fn, a, wd, 5'd5, tag);
    n0 = nreq;
    check({tag, ".req"}, 64'(m_req), 64'd1);
    check({tag, ".addr"}, 64'(m_addr), 64'(e_addr));
    check({tag, ".rmask"}, 64'(m_rm), 64'(e_rm));
    check({tag, ".wmask"}, 64'(m_wm), 64'(e_wm));
    check({tag, ".wdata"}, m_wd, e_wd);
    @(negedge clk);
    repeat (dly) @(negedge clk);
    resp = 1'b1; rdata = rdat;
    @(negedge clk);
    resp = 1'b0; rdata = '0;
    check({tag, ".ov"}, 64'(m_ov), 64'd1);
    check({tag, ".data"}, m_od, e_out);
    check({tag, ".rd"}, 64'(m_rd), 64'd5);
    check({tag, ".mis"}, 64'(m_mis), 64'd0);
    check({tag, ".npulse"}, 64'(nreq - n0), 64'd1);
  endtask

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("rst.ov", 64'(m_ov), 64'd0);
    check("rst.req", 64'(m_req), 64'd0);
    check("rst.addr", 64'(m_addr), 64'd0);
    check("rst.rmask", 64'(m_rm), 64'd0);
    check("rst.wdata", m_wd, 64'd0);
    check("rst.data", m_od, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", 64'(m_ready), 64'd1);

    // 32-bit loads and stores
    mem_op(1, 0, 3'd0, 32'h1003, 0, 64'h8000_0000, 0,
           32'h1000, 8'h8, 8'h0, 64'h0,
           64'hFFFF_FF80, "lb");
    mem_op(1, 0, 3'd4, 32'h1003, 0, 64'h8000_0000, 0,
           32'h1000, 8'h8, 8'h0, 64'h0,
           64'h0000_0080, "lbu");
    mem_op(0, 1, 3'd1, 32'h1002, 64'h1234_ABCD, 0, 1,
           32'h1000, 8'h0, 8'hC, 64'hABCD_0000,
           64'h0, "sh");
    mem_op(1, 0, 3'd1, 32'h1002, 0, 64'h8001_0000, 0,
           32'h1000, 8'hC, 8'h0, 64'h0,
           64'hFFFF_8001, "lh");
    mem_op(1, 0, 3'd7, 32'h1001, 0, 64'h0000_F000, 0,
           32'h1000, 8'h2, 8'h0, 64'h0,
           64'h0000_00F0, "f3bad");

`ifdef MEM_MISALIGN_TRAP_EN
    n0 = nreq;
    issue(1, 0, 3'd2, 32'h1001, 0, 5'd6, "trap");
    check("trap.req", 64'(m_req), 64'd0);
    check("trap.ov", 64'(m_ov), 64'd1);
    check("trap.mis", 64'(m_mis), 64'd1);
    check("trap.data", m_od, 64'd0);
    check("trap.rd", 64'(m_rd), 64'd6);
    @(negedge clk);
    check("trap.npulse", 64'(nreq - n0), 64'd0);
`else
    mem_op(1, 0, 3'd2, 32'h1001, 0, 64'hDEAD_BEEF, 0,
           32'h1000, 8'hF, 8'h0, 64'h0,
           64'hDEAD_BEEF, "lwmis");
`endif

    // pass-through
    issue(0, 0, 3'd0, 32'h55AA_1234, 0, 5'd7, "pt");
    check("pt.ov", 64'(m_ov), 64'd1);
    check("pt.data", m_od, 64'h55AA_1234);
    check("pt.rd", 64'(m_rd), 64'd7);
    check("pt.req", 64'(m_req), 64'd0);

    // long latency with downstream stall
    issue(1, 0, 3'd2, 32'h1004, 0, 5'd9, "slow");
    n0 = nreq;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("slow.rdyw", 64'(m_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    resp = 1'b1; rdata = 64'h1122_3344;
    #1 check("slow.rdyr", 64'(m_ready), 64'd0);
    @(negedge clk);
    resp = 1'b0; rdata = '0;
    check("slow.ov", 64'(m_ov), 64'd1);
    check("slow.data", m_od, 64'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("slow.rdys", 64'(m_ready), 64'd0);
      check("slow.hold", 64'(m_ov), 64'd1);
      check("slow.stab", m_od, 64'h1122_3344);
    end
    out_ready = 1'b1;
    #1 check("slow.rdy1", 64'(m_ready), 64'd1);
    @(negedge clk);
    check("slow.drain", 64'(m_ov), 64'd0);
    check("slow.npulse", 64'(nreq - n0), 64'd1);

    // flush while waiting
    issue(1, 0, 3'd2, 32'h1000, 0, 5'd4, "fl");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl.ov0", 64'(m_ov), 64'd0);
    @(negedge clk);
    resp = 1'b1; rdata = 64'hCAFE_F00D;
    in_valid = 1'b1; in_addr = 32'h77; in_rd = 5'd3;
    #1 check("fl.rdy0", 64'(m_ready), 64'd0);
    @(negedge clk);
    resp = 1'b0;
    check("fl.ov1", 64'(m_ov), 64'd0);
    #1 check("fl.rdy1", 64'(m_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("fl.next", 64'(m_ov), 64'd1);
    check("fl.ndata", m_od, 64'h77);

    // flush and in_valid together
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h99; flush = 1'b1;
    #1 check("flv.rdy", 64'(m_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flv.ov", 64'(m_ov), 64'd0);

    // reset mid-wait, then a stray response
    issue(1, 0, 3'd2, 32'h1000, 0, 5'd2, "rw");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rw.rdy", 64'(m_ready), 64'd1);
    check("rw.req", 64'(m_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp = 1'b1; rdata = 64'h1234;
    @(negedge clk);
    resp = 1'b0;
    check("rw.ov", 64'(m_ov), 64'd0);
    check("rw.rdy2", 64'(m_ready), 64'd1);

    // 64-bit instance
    sel = 1'b1;
    @(negedge clk);
    mem_op(1, 0, 3'd3, 32'h2000, 0,
           64'h8000_0000_0000_0001, 0,
           32'h2000, 8'hFF, 8'h0, 64'h0,
           64'h8000_0000_0000_0001, "ld");
    mem_op(1, 0, 3'd2, 32'h2004, 0,
           64'h8000_0000_0000_0001, 0,
           32'h2000, 8'hF0, 8'h0, 64'h0,
           64'hFFFF_FFFF_8000_0000, "lw64");
    mem_op(1, 0, 3'd6, 32'h2004, 0,
           64'h8000_0000_0000_0001, 2,
           32'h2000, 8'hF0, 8'h0, 64'h0,
           64'h0000_0000_8000_0000, "lwu");
    mem_op(1, 0, 3'd1, 32'h2006, 0,
           64'h8001_0000_0000_0000, 0,
           32'h2000, 8'hC0, 8'h0, 64'h0,
           64'hFFFF_FFFF_FFFF_8001, "lh64");
    mem_op(0, 1, 3'd3, 32'h2008,
           64'h0123_4567_89AB_CDEF, 0, 0,
           32'h2008, 8'h0, 8'hFF,
           64'h0123_4567_89AB_CDEF, 64'h0, "sd");
    mem_op(0, 1, 3'd0, 32'h2005,
           64'hFFFF_FFFF_FFFF_FFAB, 0, 0,
           32'h2000, 8'h0, 8'h20,
           64'h0000_AB00_0000_0000, 64'h0, "sb64");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
